// File: rtl/aurora_gen_pkg.sv
// Shared definitions for the Aurora AXI4-Stream frame generator and its RX checker:
// FSM state encoding, default-configuration widths, width helpers and a saturating increment.
package aurora_gen_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_UP = 3'd1,
        SEND    = 3'd2,
        GAP     = 3'd3,
        DONE    = 3'd4
    } gen_state_t;

    // Widths for the default configuration (32-bit data, 19-beat frames)
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_FRAME_LEN = 19;
    localparam int KEEP_W        = DEF_DATA_W / 8;
    localparam int BEAT_W        = $clog2(DEF_FRAME_LEN + 1);

    // Same derivations for an arbitrary instance configuration
    function automatic int calc_keep_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int calc_beat_w(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

    // Counter increment that sticks at max_v instead of wrapping
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max_v);
        return (v >= max_v) ? max_v : v + 16'd1;
    endfunction

endpackage

// File: rtl/aurora_axis_frame_chk.sv
// RX-side frame checker: tracks the expected arithmetic sequence and frame boundaries,
// counts mismatching beats and flags a clean run once NUM_FRAMES frames arrived error-free.
module aurora_axis_frame_chk
    import aurora_gen_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                FRAME_LEN  = 19,
    parameter int                NUM_FRAMES = 3,
    parameter logic [DATA_W-1:0] START_VAL  = '0,
    parameter logic [DATA_W-1:0] STEP       = DATA_W'(4)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic [0:DATA_W-1] rx_tdata,
    input  logic              rx_tvalid,
    input  logic              rx_tlast,
    output logic [15:0]       err_cnt,
    output logic              ok
);

    localparam int                L_BEAT_W  = calc_beat_w(FRAME_LEN);
    localparam logic [L_BEAT_W-1:0] LAST_BEAT = L_BEAT_W'(FRAME_LEN - 1);
    localparam logic [31:0]       NF_U      = 32'(NUM_FRAMES);

    logic [DATA_W-1:0]   r_exp;
    logic [L_BEAT_W-1:0] r_beat;
    logic [15:0]         r_frames;
    logic [15:0]         r_err;
    logic                r_ok;

    logic [DATA_W-1:0]   w_rx;
    logic                w_beat_last;
    logic                w_bad;

    assign w_rx        = rx_tdata;
    assign w_beat_last = (r_beat == LAST_BEAT);
    assign w_bad       = (w_rx != r_exp) || (rx_tlast != w_beat_last);
    assign err_cnt     = r_err;
    assign ok          = r_ok;

    // Expected-value tracking, error counting and run-complete flag; resync on mismatch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp    <= START_VAL;
            r_beat   <= '0;
            r_frames <= '0;
            r_err    <= '0;
            r_ok     <= 1'b0;
        end else if (restart) begin
            r_exp    <= START_VAL;
            r_beat   <= '0;
            r_frames <= '0;
            r_err    <= '0;
            r_ok     <= 1'b0;
        end else if (rx_tvalid) begin
            r_exp  <= (w_bad ? w_rx : r_exp) + STEP;
            r_beat <= (rx_tlast || w_beat_last) ? '0 : r_beat + 1'b1;
            if (rx_tlast)
                r_frames <= sat_inc(r_frames, 16'hFFFF);
            if (w_bad) begin
                r_err <= sat_inc(r_err, 16'hFFFF);
                r_ok  <= 1'b0;
            end else if (rx_tlast && (r_err == 16'd0) && (NF_U != 32'd0) &&
                         (({16'd0, r_frames} + 32'd1) >= NF_U)) begin
                r_ok <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/aurora_axis_frame_gen.sv
// AXI4-Stream frame generator for the Aurora 8B/10B s_axi_tx port.
// Emits NUM_FRAMES frames of FRAME_LEN beats carrying an arithmetic sequence, gated on
// channel_up; a link drop rewinds to the first beat of the interrupted frame.
// Optional RX checker enabled by defining FRAME_CHECK_EN.
module aurora_axis_frame_gen
    import aurora_gen_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                FRAME_LEN  = 19,
    parameter int                NUM_FRAMES = 3,
    parameter logic [DATA_W-1:0] START_VAL  = '0,
    parameter logic [DATA_W-1:0] STEP       = DATA_W'(4),
    parameter int                GAP_CYCLES = 0
) (
    input  logic                user_clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                channel_up,
    output logic [0:DATA_W-1]   s_axi_tx_tdata,
    output logic [0:DATA_W/8-1] s_axi_tx_tkeep,
    output logic                s_axi_tx_tvalid,
    output logic                s_axi_tx_tlast,
    input  logic                s_axi_tx_tready,
    output logic                busy,
    output logic                done,
    output logic [7:0]          abort_cnt,
    output logic [15:0]         frame_cnt
`ifdef FRAME_CHECK_EN
    ,
    input  logic [0:DATA_W-1]   m_axi_rx_tdata,
    input  logic                m_axi_rx_tvalid,
    input  logic                m_axi_rx_tlast,
    output logic [15:0]         rx_err_cnt,
    output logic                rx_ok
`endif
);

    localparam int                  L_KEEP_W  = calc_keep_w(DATA_W);
    localparam int                  L_BEAT_W  = calc_beat_w(FRAME_LEN);
    localparam logic [L_BEAT_W-1:0] LAST_BEAT = L_BEAT_W'(FRAME_LEN - 1);
    localparam logic [7:0]          GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [31:0]         NF_U      = 32'(NUM_FRAMES);

    gen_state_t          r_state;
    gen_state_t          w_next;
    logic [DATA_W-1:0]   r_value;
    logic [DATA_W-1:0]   r_base;
    logic [L_BEAT_W-1:0] r_beat;
    logic [7:0]          r_gap;
    logic [7:0]          r_abort;
    logic [15:0]         r_frames;
    logic                r_done;

    logic w_last;
    logic w_hs;
    logic w_frame_end;
    logic w_run_end;
    logic w_link_lost;
    logic w_start_acc;
    logic w_gap_end;

    // A beat only counts when the link is still up; a simultaneous drop wins
    assign w_last      = (r_beat == LAST_BEAT);
    assign w_hs        = (r_state == SEND) && s_axi_tx_tready && channel_up;
    assign w_frame_end = w_hs && w_last;
    assign w_run_end   = stop || ((NF_U != 32'd0) && (({16'd0, r_frames} + 32'd1) == NF_U));
    assign w_link_lost = !channel_up && ((r_state == SEND) || (r_state == GAP));
    assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_gap_end   = (r_gap == GAP_LAST);

    assign abort_cnt = r_abort;
    assign frame_cnt = r_frames;
    assign done      = r_done;

    // State register
    always_ff @(posedge user_clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = WAIT_UP;
            WAIT_UP:    if (channel_up) w_next = SEND;
            SEND: begin
                if (!channel_up)
                    w_next = WAIT_UP;
                else if (w_frame_end) begin
                    if (w_run_end)
                        w_next = DONE;
                    else if (GAP_CYCLES > 0)
                        w_next = GAP;
                end
            end
            GAP: begin
                if (!channel_up)
                    w_next = WAIT_UP;
                else if (w_gap_end)
                    w_next = SEND;
            end
            default:    w_next = IDLE;
        endcase
    end

    // Stream outputs decoded from state; data and tlast hold while the beat is pending
    always_comb begin
        s_axi_tx_tvalid = (r_state == SEND);
        s_axi_tx_tlast  = (r_state == SEND) && w_last;
        s_axi_tx_tkeep  = (r_state == SEND) ? {L_KEEP_W{1'b1}} : {L_KEEP_W{1'b0}};
        s_axi_tx_tdata  = r_value;
        busy            = (r_state == WAIT_UP) || (r_state == SEND) || (r_state == GAP);
    end

    // Sequence value, frame base, beat/gap counters and status counters
    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            r_value  <= '0;
            r_base   <= '0;
            r_beat   <= '0;
            r_gap    <= '0;
            r_abort  <= '0;
            r_frames <= '0;
        end else if (w_start_acc) begin
            r_value  <= START_VAL;
            r_base   <= START_VAL;
            r_beat   <= '0;
            r_gap    <= '0;
            r_abort  <= '0;
            r_frames <= '0;
        end else if (w_link_lost) begin
            r_value <= r_base;
            r_beat  <= '0;
            r_gap   <= '0;
            r_abort <= 8'(sat_inc({8'd0, r_abort}, 16'd255));
        end else if (w_hs) begin
            r_value <= r_value + STEP;
            r_gap   <= '0;
            if (w_last) begin
                r_beat   <= '0;
                r_frames <= r_frames + 16'd1;
                r_base   <= r_value + STEP;
            end else begin
                r_beat <= r_beat + 1'b1;
            end
        end else if (r_state == GAP) begin
            r_gap <= r_gap + 8'd1;
        end
    end

    // One-cycle done pulse on entry to DONE
    always_ff @(posedge user_clk or posedge reset) begin
        if (reset)
            r_done <= 1'b0;
        else
            r_done <= (w_next == DONE) && (r_state != DONE);
    end

`ifdef FRAME_CHECK_EN
    aurora_axis_frame_chk #(
        .DATA_W     (DATA_W),
        .FRAME_LEN  (FRAME_LEN),
        .NUM_FRAMES (NUM_FRAMES),
        .START_VAL  (START_VAL),
        .STEP       (STEP)
    ) u_chk (
        .clk       (user_clk),
        .rst       (reset),
        .restart   (w_start_acc),
        .rx_tdata  (m_axi_rx_tdata),
        .rx_tvalid (m_axi_rx_tvalid),
        .rx_tlast  (m_axi_rx_tlast),
        .err_cnt   (rx_err_cnt),
        .ok        (rx_ok)
    );
`endif

endmodule

// File: tb/tb_aurora_axis_frame_gen.sv
// Bench for aurora_axis_frame_gen: two instances (default config; short wrapping frames
// with gaps and continuous mode) driven by directed and randomized stimulus, checked
// against a beat-index model: beat n of a run is START_VAL + STEP*n, tlast at n%FRAME_LEN.
module tb_aurora_axis_frame_gen;

    localparam int          P_FL  [2] = '{19, 5};
    localparam int          P_GAP [2] = '{0, 5};
    localparam logic [31:0] P_SV  [2] = '{32'h0, 32'hFFFF_FF00};
    localparam logic [31:0] P_ST  [2] = '{32'd4, 32'd37};

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [2];
    logic        stop_s  [2];
    logic        cu_s    [2];
    logic        rdy_s   [2];
    logic [0:31] tdata   [2];
    logic [0:3]  tkeep   [2];
    logic        tvalid  [2];
    logic        tlast   [2];
    logic        busy    [2];
    logic        done    [2];
    logic [7:0]  abort   [2];
    logic [15:0] fcnt    [2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // model state
    int          m_n      [2];
    int          m_frames [2];
    int          m_hs     [2];
    int          m_drops  [2];
    int          m_done   [2];
    int          m_gapcnt [2];
    bit          m_gapflag[2];
    bit          m_gapchk [2];
    bit          m_drop   [2];
    bit          m_hold   [2];
    logic [31:0] m_hdata  [2];
    bit          m_hlast  [2];
    logic [31:0] m_hist0  [$];

    always #5 clk = ~clk;

`ifdef FRAME_CHECK_EN
    logic [0:31] rx_tdata0;
    logic        rx_tvalid0;
    logic        corrupt_en = 1'b0;
    logic [15:0] rx_err [2];
    logic        rx_ok  [2];
    logic [0:31] rx_tdata1 = '0;
    logic        rx_tvalid1 = 1'b0;
    logic        rx_tlast1 = 1'b0;
    assign rx_tvalid0 = tvalid[0] & rdy_s[0] & cu_s[0];
    assign rx_tdata0  = tdata[0] ^ ((corrupt_en && tlast[0] && (tdata[0] == 32'd224)) ? 32'h1 : 32'h0);
`endif

    aurora_axis_frame_gen #(
        .DATA_W(32), .FRAME_LEN(19), .NUM_FRAMES(3),
        .START_VAL(32'h0), .STEP(32'd4), .GAP_CYCLES(0)
    ) dut_a (
        .user_clk(clk), .reset(rst), .start(start_s[0]), .stop(stop_s[0]),
        .channel_up(cu_s[0]), .s_axi_tx_tdata(tdata[0]), .s_axi_tx_tkeep(tkeep[0]),
        .s_axi_tx_tvalid(tvalid[0]), .s_axi_tx_tlast(tlast[0]), .s_axi_tx_tready(rdy_s[0]),
        .busy(busy[0]), .done(done[0]), .abort_cnt(abort[0]), .frame_cnt(fcnt[0])
`ifdef FRAME_CHECK_EN
        , .m_axi_rx_tdata(rx_tdata0), .m_axi_rx_tvalid(rx_tvalid0), .m_axi_rx_tlast(tlast[0]),
        .rx_err_cnt(rx_err[0]), .rx_ok(rx_ok[0])
`endif
    );

    aurora_axis_frame_gen #(
        .DATA_W(32), .FRAME_LEN(5), .NUM_FRAMES(0),
        .START_VAL(32'hFFFF_FF00), .STEP(32'd37), .GAP_CYCLES(5)
    ) dut_b (
        .user_clk(clk), .reset(rst), .start(start_s[1]), .stop(stop_s[1]),
        .channel_up(cu_s[1]), .s_axi_tx_tdata(tdata[1]), .s_axi_tx_tkeep(tkeep[1]),
        .s_axi_tx_tvalid(tvalid[1]), .s_axi_tx_tlast(tlast[1]), .s_axi_tx_tready(rdy_s[1]),
        .busy(busy[1]), .done(done[1]), .abort_cnt(abort[1]), .frame_cnt(fcnt[1])
`ifdef FRAME_CHECK_EN
        , .m_axi_rx_tdata(rx_tdata1), .m_axi_rx_tvalid(rx_tvalid1), .m_axi_rx_tlast(rx_tlast1),
        .rx_err_cnt(rx_err[1]), .rx_ok(rx_ok[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic new_run(input int d);
        m_n[d] = 0; m_frames[d] = 0; m_hs[d] = 0; m_drops[d] = 0; m_done[d] = 0;
        m_gapcnt[d] = 0; m_gapflag[d] = 0; m_drop[d] = 0; m_hold[d] = 0;
        if (d == 0) m_hist0.delete();
    endtask

    // One clock: drive inputs at negedge, then observe and advance the model
    task automatic cycle(input int d, input bit st, input bit rdy, input bit cu, input bit stp);
        int          i;
        logic [31:0] want;
        @(negedge clk);
        start_s[d] = st; rdy_s[d] = rdy; cu_s[d] = cu; stop_s[d] = stp;
        #1;
        if (m_drop[d]) chk("drop_tvalid_low", 32'(tvalid[d]), 32'd0);
        if (m_hold[d]) begin
            chk("hold_tvalid", 32'(tvalid[d]), 32'd1);
            chk("hold_tdata", tdata[d], m_hdata[d]);
            chk("hold_tlast", 32'(tlast[d]), 32'(m_hlast[d]));
        end
        m_drop[d]  = tvalid[d] && !cu;
        m_hold[d]  = tvalid[d] && !rdy && cu;
        m_hdata[d] = tdata[d];
        m_hlast[d] = tlast[d];
        if (done[d]) m_done[d]++;
        if (tvalid[d] && m_gapflag[d]) begin
            if (m_gapchk[d]) chk("gap_len", 32'(m_gapcnt[d]), 32'(P_GAP[d]));
            m_gapflag[d] = 0;
        end
        if (tvalid[d] && cu && rdy) begin
            i    = m_n[d] % P_FL[d];
            want = P_SV[d] + P_ST[d] * 32'(m_n[d]);
            chk("beat_data", tdata[d], want);
            chk("beat_tlast", 32'(tlast[d]), 32'(i == P_FL[d] - 1));
            chk("beat_tkeep", 32'(tkeep[d]), 32'hF);
            if (d == 0) m_hist0.push_back(tdata[d]);
            m_n[d]++;
            m_hs[d]++;
            if (i == P_FL[d] - 1) begin
                m_frames[d]++;
                m_gapflag[d] = 1;
                m_gapcnt[d]  = 0;
            end
        end else if (tvalid[d] && !cu) begin
            m_n[d] = m_frames[d] * P_FL[d];
            m_drops[d]++;
            m_gapflag[d] = 0;
        end else if (!tvalid[d] && m_gapflag[d]) begin
            m_gapcnt[d]++;
        end
    endtask

    task automatic chk_idle_outputs(input int d);
        chk("rst_tvalid", 32'(tvalid[d]), 32'd0);
        chk("rst_tlast", 32'(tlast[d]), 32'd0);
        chk("rst_tkeep", 32'(tkeep[d]), 32'd0);
        chk("rst_tdata", tdata[d], 32'd0);
        chk("rst_busy", 32'(busy[d]), 32'd0);
        chk("rst_done", 32'(done[d]), 32'd0);
        chk("rst_abort", 32'(abort[d]), 32'd0);
        chk("rst_fcnt", 32'(fcnt[d]), 32'd0);
    endtask

    initial begin
        bit cu;
        int down;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 0; stop_s[d] = 0; cu_s[d] = 0; rdy_s[d] = 0;
            m_gapchk[d] = 0;
            new_run(d);
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle_outputs(0);
        chk_idle_outputs(1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk_idle_outputs(0);

        // Plain run with a start pulse while busy that must be ignored
        new_run(0);
        m_gapchk[0] = 1;
        for (int c = 0; c < 120; c++) cycle(0, (c == 0) || (c == 30), 1, 1, 0);
        chk("t1_beats", 32'(m_hs[0]), 32'd57);
        chk("t1_frames", 32'(fcnt[0]), 32'd3);
        chk("t1_done_pulses", 32'(m_done[0]), 32'd1);
        chk("t1_busy", 32'(busy[0]), 32'd0);
        chk("t1_last_value", m_hist0[56], 32'd224);
`ifdef FRAME_CHECK_EN
        chk("t1_rx_ok", 32'(rx_ok[0]), 32'd1);
        chk("t1_rx_err", 32'(rx_err[0]), 32'd0);
`endif

        // Random backpressure, restart from DONE, one corrupted RX beat
        new_run(0);
        m_gapchk[0] = 0;
`ifdef FRAME_CHECK_EN
        corrupt_en = 1'b1;
`endif
        for (int c = 0; c < 400; c++) cycle(0, c == 0, 1'($urandom_range(0, 1)), 1, 0);
        chk("t2_beats", 32'(m_hs[0]), 32'd57);
        chk("t2_frames", 32'(fcnt[0]), 32'd3);
        chk("t2_done_pulses", 32'(m_done[0]), 32'd1);
        chk("t2_busy", 32'(busy[0]), 32'd0);
`ifdef FRAME_CHECK_EN
        chk("t2_rx_err", 32'(rx_err[0]), 32'd1);
        chk("t2_rx_ok", 32'(rx_ok[0]), 32'd0);
        corrupt_en = 1'b0;
`endif

        // Link drop right after the 25th handshake
        new_run(0);
        down = 0;
        for (int c = 0; c < 200; c++) begin
            cu = 1;
            if (m_hs[0] >= 25 && down < 3) begin
                cu = 0;
                down++;
            end
            cycle(0, c == 0, 1, cu, 0);
        end
        chk("t3_value_before_drop", m_hist0[24], 32'd96);
        chk("t3_resume_value", m_hist0[25], 32'd76);
        chk("t3_abort_cnt", 32'(abort[0]), 32'd1);
        chk("t3_beats", 32'(m_hs[0]), 32'd63);
        chk("t3_frames", 32'(fcnt[0]), 32'd3);
        chk("t3_done_pulses", 32'(m_done[0]), 32'd1);

        // Random link drops and backpressure
        new_run(0);
        for (int c = 0; c < 3000; c++)
            cycle(0, c == 0, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) != 0), 0);
        chk("tr_model_frames", 32'(m_frames[0]), 32'd3);
        chk("tr_frames", 32'(fcnt[0]), 32'd3);
        chk("tr_abort_cnt", 32'(abort[0]), 32'((m_drops[0] > 255) ? 255 : m_drops[0]));
        chk("tr_done_pulses", 32'(m_done[0]), 32'd1);
        chk("tr_busy", 32'(busy[0]), 32'd0);

        // Continuous mode with gaps and wrapping data; stop raised mid-frame 4
        new_run(1);
        m_gapchk[1] = 1;
        for (int c = 0; c < 300; c++) cycle(1, c == 0, 1, 1, m_hs[1] >= 17);
        chk("t5_beats", 32'(m_hs[1]), 32'd20);
        chk("t5_frames", 32'(fcnt[1]), 32'd4);
        chk("t5_done_pulses", 32'(m_done[1]), 32'd1);
        chk("t5_busy", 32'(busy[1]), 32'd0);
        chk("t5_tvalid", 32'(tvalid[1]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aurora_axis_frame_gen.md
Name: aurora_axis_frame_gen

Overview:
Parametrised AXI4-Stream frame generator driving the Aurora 8B/10B core's s_axi_tx user interface.
- Emits NUM_FRAMES frames of FRAME_LEN beats each. Data is an arithmetic sequence, tlast marks each frame end.
- Gated on channel_up; restarts the interrupted frame if the link drops.
- Sits between the initial-sequence FSM and the Aurora TX port, clocked by the Aurora user clock.
- Supersedes the fixed 3x19, step-4 TX FSM.

Parameters:
DATA_W, 32, TX data width in bits; multiple of 8, 16..64
FRAME_LEN, 19, beats per frame; >=1
NUM_FRAMES, 3, frames per run; 0 = continuous until stop
START_VAL, 0, value of first beat of the run
STEP, 4, increment between consecutive beats, carried across frames
GAP_CYCLES, 0, idle cycles with tvalid low between frames; 0..255

Ports:
user_clk  in  1  Aurora user clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
stop  in  1  level; finish current frame, then go DONE
channel_up  in  1  Aurora channel status
s_axi_tx_tdata  out  [0:DATA_W-1]  TX data, Aurora bit order (bit 0 = MSB)
s_axi_tx_tkeep  out  [0:DATA_W/8-1]  byte enables, constant all ones while valid
s_axi_tx_tvalid  out  1  beat valid
s_axi_tx_tlast  out  1  final beat of frame
s_axi_tx_tready  in  1  Aurora ready
busy  out  1  high from start acceptance until DONE
done  out  1  one-cycle pulse entering DONE
abort_cnt  out  8  saturating count of link-drop restarts
frame_cnt  out  16  completed frames, wraps

Behaviour:
Reset:
- All outputs 0; state IDLE; internal value and beat/frame counters 0.

States:
- IDLE -> WAIT_UP on start. Load value <= START_VAL, frame base <= START_VAL. Clear beat, frame and abort counters.
- WAIT_UP -> SEND when channel_up=1; first tvalid the cycle after the transition.
- SEND: tvalid=1, tdata=value, tlast=(beat==FRAME_LEN-1).
- SEND, on tvalid&tready: value += STEP; beat++.
- SEND, on the tlast handshake: frame_cnt++, beat <= 0, frame base <= value+STEP. Then:
  - -> DONE if frame count reached NUM_FRAMES (NUM_FRAMES!=0) or stop=1;
  - else -> GAP if GAP_CYCLES>0;
  - else stay in SEND (back-to-back frames, no bubble).
- GAP: count GAP_CYCLES cycles with tvalid=0 -> SEND.
- DONE: done pulses for 1 cycle on entry, busy=0. -> WAIT_UP on start (fresh run, same as from IDLE).

Handshake:
- Once tvalid=1, tdata/tlast/tkeep are held stable until tready.
- tvalid is never deasserted without a handshake, except on channel_up loss.
- tready with tvalid=0 is ignored.

Link loss (channel_up=0 in SEND or GAP):
- tvalid=0 the next cycle.
- value <= frame base, beat <= 0, abort_cnt++ (saturates at 255); -> WAIT_UP.
- The interrupted frame is resent from its first beat; completed frames are not resent.

Simultaneous events:
- tready handshake and channel_up fall in the same cycle: link loss wins; the beat is not counted.
- start while busy: ignored.
- stop is sampled only at the tlast handshake.

Arithmetic:
- value wraps modulo 2^DATA_W.
- Beat i of frame k = START_VAL + STEP*(k*FRAME_LEN+i) mod 2^DATA_W.

Optional Feature:
FRAME_CHECK_EN
- Defined: adds RX-side ports m_axi_rx_tdata [0:DATA_W-1], m_axi_rx_tvalid, m_axi_rx_tlast (inputs), plus rx_err_cnt (out, 16, saturating) and rx_ok (out, 1).
- A checker keeps its own expected value from START_VAL and compares each received valid beat. Mismatch in data, or tlast at the wrong beat -> rx_err_cnt++, and the checker resynchronises expected to received+STEP.
- rx_ok=1 after NUM_FRAMES frames are received with zero errors.
- Checker resets on reset and on start.
- Undefined: ports absent, no checker logic.

Decomposition:
Shared package aurora_gen_pkg holds:
- state enum {IDLE, WAIT_UP, SEND, GAP, DONE};
- localparams KEEP_W=DATA_W/8 and BEAT_W=$clog2(FRAME_LEN+1);
- the saturating-increment function.

One natural sub-module: aurora_axis_frame_chk, the RX checker, instantiated only under FRAME_CHECK_EN.

Test Plan:
1. Defaults, channel_up=1, tready=1, one start pulse:
   - 57 beats: 0,4,...,224.
   - tlast only on 72, 148, 224; frame_cnt=3; done pulses once; busy falls.
2. Backpressure: tready toggles with a pseudo-random pattern:
   - data/tlast stable while tvalid&!tready; same 57-value sequence.
3. channel_up drops after the 25th handshake (value 96, frame 1):
   - tvalid low the next cycle; abort_cnt=1.
   - On recovery the stream resumes at 76, then 76..148; total frames=3.
4. GAP_CYCLES=5, NUM_FRAMES=2:
   - exactly 5 tvalid-low cycles between 72 and 76.
5. NUM_FRAMES=0, stop asserted mid-frame 4:
   - frame 4 completes with tlast; DONE entered; no further beats.
6. FRAME_CHECK_EN, TX looped to RX:
   - rx_ok=1, rx_err_cnt=0.
   - Inject one corrupted beat -> rx_err_cnt=1, rx_ok stays 0.
